instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Instruction-fetch sequencer for the reduced RISC-V core. It owns the program counter, drives the word address of the combinational instruction ROM, and registers each instruction plus its PC into a one-entry output stage with a valid/ready handshake to decode. It accepts branch/jump redirects and a halt request. While halted it lends the ROM read port to a debug/loader requester.

## Interface
- ADDRESS_WIDTH, 12, ROM word-address width (2**ADDRESS_WIDTH words)
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDRESS_WIDTH  word address to ROM (combinational from state)
- imem_rd  in  DATA_WIDTH  ROM read data (combinational from imem_addr)
- redirect_valid  in  1  load redirect_pc as next fetch PC
- redirect_pc  in  32  redirect target byte address
- halt  in  1  level; stop fetching and hand ROM port to debug
- out_valid  out  1  out_instr/out_pc hold a fetched instruction
- out_ready  in  1  decode accepts this cycle
- out_instr  out  DATA_WIDTH  fetched instruction
- out_pc  out  32  byte PC of out_instr
- halted  out  1  FSM is in HALTED
- dbg_req  in  1  debug read request (honoured only in HALTED)
- dbg_addr  in  ADDRESS_WIDTH  debug word address
- dbg_ack  out  1  one-cycle pulse: dbg_rdata valid
- dbg_rdata  out  DATA_WIDTH  debug read data

## Operation
- Registers: pc (32b), out stage {out_valid, out_instr, out_pc}, state ∈ {RUN, HALTED}, dbg_ack, dbg_rdata.
- Reset values: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, state=RUN, halted=0, dbg_ack=0, dbg_rdata=0. Reset overrides all other inputs.
- imem_addr = pc[ADDRESS_WIDTH+1:2] in RUN; dbg_addr in HALTED.
- Stage free this cycle ⇔ !out_valid || out_ready.
- Per-cycle priority in RUN: (1) redirect, (2) halt, (3) fetch, (4) hold.
  - Redirect: pc ← {redirect_pc[31:2],2'b00}; out_valid ← 0 (held instruction dropped regardless of out_ready); no fetch this cycle. If halt is also high, state ← HALTED.
  - Halt (no redirect): no new fetch. If stage free: out_valid ← 0, state ← HALTED. Else hold out stage and stay RUN until it is accepted.
  - Fetch (stage free): out_instr ← imem_rd, out_pc ← pc, out_valid ← 1, pc ← pc+4.
  - Hold (out_valid && !out_ready): all registers unchanged; out_instr/out_pc stable.
- HALTED:
  - out_valid=0. pc frozen except by redirect, which updates pc.
  - dbg_req: dbg_rdata ← imem_rd, dbg_ack ← 1 next cycle. Back-to-back requests give one ack per request cycle. dbg_req in RUN is ignored (never acked) and stays pending until HALTED.
  - halt low: state ← RUN. Fetch resumes the following cycle from pc. A dbg_req in the exiting cycle is still served.
- Arithmetic: pc+4 wraps modulo 2^32. ROM address uses only pc[ADDRESS_WIDTH+1:2], so fetch wraps modulo ROM size while out_pc keeps the full 32-bit value. redirect_pc[1:0] is ignored.

## Timing
- Reset released before edge E0: first fetch at E0, out_valid=1 with out_pc=RESET_PC after E0.
- Steady state with out_ready=1: one instruction per cycle, out_pc increments by 4.
- Redirect sampled at edge E: out_valid=0 after E; target instruction valid after E+1 (2-cycle bubble-to-valid).
- Halt sampled at E with stage free: halted=1 after E. Debug request at E' yields dbg_ack=1 after E' for exactly one cycle.
- Halt release at E: halted=0 after E; next instruction valid after E+1.

## Test plan
- Reset then out_ready=1, ROM words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00308193 -> out_pc 0,4,8,C with the matching out_instr on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles at out_pc=8 -> out_pc/out_instr stable at 8/0x00200113, pc not advanced; release -> next out_pc=C.
- Redirect to 0x42 while out_valid=1 and out_ready=0 -> held instruction dropped, out_valid=0 one cycle, then out_pc=0x40 with ROM[16].
- Halt during backpressure -> stays RUN until accept; then halted=1. dbg_req addr 5 -> dbg_ack pulse with ROM[5]. Release -> fetch resumes at saved pc.
- Wrap: RESET_PC=0x3FFC (ADDRESS_WIDTH=12) -> out_pc 0x3FFC (ROM[4095]) then 0x4000 (ROM[0]).
- Redirect and halt same cycle, then rst asserted mid-HALTED -> HALTED with pc=target; after reset all outputs at reset values and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, feeds a one-entry decode stage,
// and lends the ROM read port to a debug requester while halted.
module instr_fetch_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rd,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [31:0]              out_pc,
  output logic                     halted,
  input  logic                     dbg_req,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
  output logic                     dbg_ack,
  output logic [DATA_WIDTH-1:0]    dbg_rdata
);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  out_valid_q, out_valid_d;
  logic                  dbg_ack_q, dbg_ack_d;
  logic                  stage_free;
  logic [31:0]           redir_tgt;

  assign stage_free = !out_valid_q || out_ready;
  assign redir_tgt  = {redirect_pc[31:2], 2'b00};

  assign imem_addr = (state_q == S_HALTED) ? dbg_addr
                                           : pc_q[ADDRESS_WIDTH+1:2];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_RUN: begin
        // Redirect beats halt beats fetch; a redirect always drops the stage.
        if (redirect_valid) begin
          pc_d        = redir_tgt;
          out_valid_d = 1'b0;
          if (halt) state_d = S_HALTED;
        end else if (halt) begin
          if (stage_free) begin
            out_valid_d = 1'b0;
            state_d     = S_HALTED;
          end
        end else if (stage_free) begin
          out_instr_d = imem_rd;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
        end
      end
      S_HALTED: begin
        out_valid_d = 1'b0;
        if (redirect_valid) pc_d = redir_tgt;
        if (dbg_req) begin
          dbg_ack_d   = 1'b1;
          dbg_rdata_d = imem_rd;
        end
        if (!halt) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == S_HALTED);
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
